// File: rtl/aes_axis_pkg.sv
// Shared types and defaults for the AES AXI4-Stream block transmitter.
package aes_axis_pkg;

    localparam int BLK_S_DEF      = 128;
    localparam int WORD_S_DEF     = 32;
    localparam int WORDS_PER_BLK  = BLK_S_DEF / WORD_S_DEF;
    localparam int CNT_W          = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef struct packed {
        logic                 last;
        logic [BLK_S_DEF-1:0] data;
    } fifo_entry_t;

    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO; exposes the head entry and the entry behind it
// so the transmitter can chain blocks without a bubble.
module aes_blk_fifo
    import aes_axis_pkg::*;
#(
    parameter int WIDTH = BLK_S_DEF + 1,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] peek,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign peek    = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/aes_axis_block_tx.sv
// Serializes buffered AES result blocks onto an AXI4-Stream master, MSW first.
//   state   | meaning
//   TX_IDLE | no beat offered, waiting for a buffered block
//   TX_SEND | beat cnt of the head block is on tdata, tvalid high
module aes_axis_block_tx
    import aes_axis_pkg::*;
#(
    parameter int BLK_S      = BLK_S_DEF,
    parameter int WORD_S     = WORD_S_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [BLK_S-1:0]  blk_data,
    input  logic              blk_last,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic [WORD_S-1:0] m00_axis_tdata,
    output logic              m00_axis_tvalid,
    input  logic              m00_axis_tready,
    output logic              m00_axis_tlast,
    output logic              busy
);

    localparam int N  = BLK_S / WORD_S;
    localparam int CW = cnt_width(N);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    tx_state_t         state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt, cnt_inc;
    logic [WORD_S-1:0] tdata_nxt;
    logic              tlast_nxt;
    logic [BLK_S:0]    head, peek;
    logic              full, empty, pop, hs;
    logic [AW:0]       count;

    function automatic logic [WORD_S-1:0] word_of(input logic [BLK_S:0] e,
                                                  input logic [CW-1:0] k);
        logic [BLK_S-1:0] sh;
        sh = e[BLK_S-1:0] << (k * WORD_S);
        return sh[BLK_S-1 -: WORD_S];
    endfunction

    aes_blk_fifo #(
        .WIDTH (BLK_S + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .push    (blk_valid),
        .wr_data ({blk_last, blk_data}),
        .pop     (pop),
        .head    (head),
        .peek    (peek),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign blk_ready       = !full;
    assign busy            = (count != '0);
    assign m00_axis_tvalid = (state == TX_SEND);
    assign hs              = m00_axis_tvalid && m00_axis_tready;
    assign cnt_inc         = cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tdata_nxt = m00_axis_tdata;
        tlast_nxt = m00_axis_tlast;
        pop       = 1'b0;
        case (state)
            TX_IDLE: begin
                if (!empty) begin
                    state_nxt = TX_SEND;
                    cnt_nxt   = '0;
                    tdata_nxt = word_of(head, '0);
                    tlast_nxt = head[BLK_S] && (CNT_LAST == '0);
                end
            end
            TX_SEND: begin
                if (hs) begin
                    if (cnt == CNT_LAST) begin
                        pop     = 1'b1;
                        cnt_nxt = '0;
                        // A second buffered entry is chained straight in.
                        if (count > (AW+1)'(1)) begin
                            tdata_nxt = word_of(peek, '0);
                            tlast_nxt = peek[BLK_S] && (CNT_LAST == '0);
                        end else begin
                            state_nxt = TX_IDLE;
                            tdata_nxt = '0;
                            tlast_nxt = 1'b0;
                        end
                    end else begin
                        cnt_nxt   = cnt_inc;
                        tdata_nxt = word_of(head, cnt_inc);
                        tlast_nxt = head[BLK_S] && (cnt_inc == CNT_LAST);
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= TX_IDLE;
            cnt            <= '0;
            m00_axis_tdata <= '0;
            m00_axis_tlast <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            m00_axis_tdata <= tdata_nxt;
            m00_axis_tlast <= tlast_nxt;
        end
    end

endmodule

// File: tb/tb_aes_axis_block_tx.sv
// Directed/randomized bench for aes_axis_block_tx against a word-queue model.
module tb_aes_axis_block_tx;

    localparam int BLK_S = 128;
    localparam int WORD_S = 32;
    localparam int N = BLK_S / WORD_S;
    localparam int DEPTH = 2;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic [BLK_S-1:0]   blk_data;
    logic               blk_last;
    logic               blk_valid;
    logic               blk_ready;
    logic [WORD_S-1:0]  tdata;
    logic               tvalid;
    logic               tready;
    logic               tlast;
    logic               busy;

    always #5 aclk = ~aclk;

    aes_axis_block_tx #(
        .BLK_S      (BLK_S),
        .WORD_S     (WORD_S),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .blk_data        (blk_data),
        .blk_last        (blk_last),
        .blk_valid       (blk_valid),
        .blk_ready       (blk_ready),
        .m00_axis_tdata  (tdata),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tready (tready),
        .m00_axis_tlast  (tlast),
        .busy            (busy)
    );

    typedef struct {
        logic [WORD_S-1:0] w;
        logic              last;
        logic              eob;
    } beat_t;

    beat_t             exp_q[$];
    int                held;
    int                total, passed, fails;
    int                cycle;
    int                beats, tlasts, first_hs, last_hs, first_eob;
    logic              prev_stall;
    logic [WORD_S-1:0] prev_data;
    logic              prev_last;
    logic              osc;
    logic              saw_not_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [BLK_S-1:0] d, input logic l);
        for (int k = 0; k < N; k++) begin
            beat_t b;
            b.w    = d[BLK_S-1-k*WORD_S -: WORD_S];
            b.last = l && (k == N - 1);
            b.eob  = (k == N - 1);
            exp_q.push_back(b);
        end
        held++;
    endtask

    task automatic clear_stats();
        beats = 0; tlasts = 0; first_hs = -1; last_hs = -1; first_eob = -1;
        saw_not_ready = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance to the next negedge.
    task automatic cyc(output logic acc);
        logic hs;
        acc = blk_valid && blk_ready;
        chk("blk_ready", blk_ready, held < DEPTH);
        chk("busy", busy, held != 0);
        if (!blk_ready) saw_not_ready = 1'b1;
        if (prev_stall) begin
            chk("stall_tvalid", tvalid, 1'b1);
            chk("stall_tdata", tdata, prev_data);
            chk("stall_tlast", tlast, prev_last);
        end
        if (exp_q.size() == 0) chk("idle_tvalid", tvalid, 1'b0);
        hs = tvalid && tready;
        if (hs && exp_q.size() > 0) begin
            beat_t b;
            b = exp_q.pop_front();
            chk("tdata", tdata, b.w);
            chk("tlast", tlast, b.last);
            beats++;
            if (tlast) tlasts++;
            if (first_hs < 0) first_hs = cycle;
            last_hs = cycle;
            if (b.eob) begin
                held--;
                if (first_eob < 0) first_eob = cycle;
            end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        if (acc) model_push(blk_data, blk_last);
        @(posedge aclk);
        @(negedge aclk);
        cycle++;
        if (osc) tready = ((cycle % 9) == 8);
    endtask

    task automatic push_blk(input logic [BLK_S-1:0] d, input logic l, output int acc_cycle);
        logic acc;
        acc = 1'b0;
        acc_cycle = -1;
        blk_valid = 1'b1;
        blk_data  = d;
        blk_last  = l;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc_cycle = cycle;
            cyc(acc);
        end
        blk_valid = 1'b0;
        chk("push_accepted", acc, 1'b1);
    endtask

    task automatic drain(input int budget);
        logic acc;
        for (int i = 0; i < budget && (exp_q.size() != 0 || held != 0); i++) cyc(acc);
        chk("drain_left", exp_q.size(), 0);
    endtask

    function automatic logic [BLK_S-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   ac, c2;
        total = 0; passed = 0; fails = 0; cycle = 0; held = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; osc = 1'b0;
        clear_stats();
        aresetn = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_last = 1'b0; tready = 1'b0;

        // Reset state
        @(negedge aclk); @(negedge aclk);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        aresetn = 1'b1;
        cyc(acc);
        chk("rst_blk_ready", blk_ready, 1'b1);

        // Single known block, tready high
        tready = 1'b1;
        clear_stats();
        blk_valid = 1'b1;
        blk_data  = 128'h00112233_44556677_8899aabb_ccddeeff;
        blk_last  = 1'b1;
        cyc(acc);
        chk("t1_acc", acc, 1'b1);
        blk_valid = 1'b0;
        chk("t1_tvalid_push_edge", tvalid, 1'b0);
        cyc(acc);
        chk("t1_tvalid_next_edge", tvalid, 1'b1);
        chk("t1_first_word", tdata, 32'h00112233);
        drain(20);
        chk("t1_beats", beats, 4);
        chk("t1_span", last_hs - first_hs, 3);
        chk("t1_tlasts", tlasts, 1);

        // Three-block request, last only on block 3
        clear_stats();
        for (int i = 0; i < 3; i++) push_blk(rand_blk(), i == 2, ac);
        drain(50);
        chk("t2_beats", beats, 12);
        chk("t2_tlasts", tlasts, 1);
        chk("t2_busy_after", busy, 1'b0);

        // tready 8 low / 1 high with continuous pushes
        clear_stats();
        osc = 1'b1;
        tready = 1'b0;
        for (int i = 0; i < 6; i++) push_blk(rand_blk(), 1'($urandom_range(0, 1)), ac);
        drain(600);
        osc = 1'b0;
        chk("t3_beats", beats, 24);
        chk("t3_ready_low", saw_not_ready, 1'b1);

        // Four blocks back-to-back, tready high
        tready = 1'b1;
        cyc(acc);
        clear_stats();
        for (int i = 0; i < 4; i++) push_blk(rand_blk(), i == 3, ac);
        drain(60);
        chk("t4_beats", beats, 16);
        chk("t4_span", last_hs - first_hs, 15);

        // Reset after beat 2 of a block
        clear_stats();
        push_blk(rand_blk(), 1'b1, ac);
        for (int i = 0; i < 20 && beats < 2; i++) cyc(acc);
        chk("t5_beats_before_rst", beats, 2);
        aresetn = 1'b0;
        #1;
        chk("t5_rst_tvalid", tvalid, 1'b0);
        chk("t5_rst_tlast", tlast, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        exp_q.delete();
        held = 0;
        prev_stall = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        clear_stats();
        for (int i = 0; i < 10; i++) cyc(acc);
        chk("t5_quiet_tvalid", tvalid, 1'b0);
        chk("t5_quiet_beats", beats, 0);
        push_blk(128'hfedcba98_76543210_0f1e2d3c_4b5a6978, 1'b1, ac);
        cyc(acc);
        chk("t5_fresh_word0", tdata, 32'hfedcba98);
        drain(20);
        chk("t5_fresh_beats", beats, 4);

        // Push while full on the cycle the head's last beat pops
        clear_stats();
        push_blk(rand_blk(), 1'b0, ac);
        push_blk(rand_blk(), 1'b0, ac);
        push_blk(rand_blk(), 1'b1, c2);
        chk("t6_push_after_pop", c2 - first_eob, 1);
        drain(40);
        chk("t6_beats", beats, 12);
        chk("t6_tlasts", tlasts, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
